truth_table_checker: RTL
========================

// Module: truth_table_checker
// PURPOSE
//  Sequential exhaustive-sweep equivalence checker for N-input Boolean functions.
//  Drives every input vector onto vec_out, samples an original-expression output (f_ref)
//  and a simplified-expression output (f_dut), and records both truth tables.
//  Reports equality, mismatch count and first mismatching vector.
//  Sits between a stimulus-free function pair and the bench or status logic.
// PARAMETERS
//  N_IN    3  number of function inputs; vec_out[N_IN-1] is x (MSB), then y, z...
//  SETTLE  1  extra hold cycles per vector before sampling (0 allowed)
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           asynchronous active-low reset
//  start         in   1           begin sweep; honoured only in IDLE
//  f_ref         in   1           output of original expression for vec_out
//  f_dut         in   1           output of simplified expression for vec_out
//  vec_out       out  N_IN        current input vector to both functions
//  busy          out  1           sweep in progress
//  done          out  1           one-cycle pulse, sweep finished
//  equal         out  1           1 = no mismatch in last sweep
//  err_count     out  N_IN+1      number of mismatching vectors (0..2^N_IN)
//  first_mm_vld  out  1           first_mm_vec is valid
//  first_mm_vec  out  N_IN        first vector (ascending order) with f_ref != f_dut
//  tt_ref        out  2^N_IN      tt_ref[v] = f_ref sampled at vector v
//  tt_dut        out  2^N_IN      tt_dut[v] = f_dut sampled at vector v
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, FSM in IDLE, equal=0.
//  - FSM: IDLE -> HOLD -> (next vector: HOLD | end: DONE) -> IDLE.
//  - IDLE: start=1 at edge E0 -> HOLD, busy=1, vec_out=0, all results cleared.
//  - HOLD: each vector is held SETTLE+1 cycles. f_ref/f_dut are sampled on the edge
//    ending the hold. That edge also writes tt bits, increments err_count on mismatch,
//    and captures first_mm_vec/first_mm_vld on the first mismatch only.
//  - Vectors are visited in ascending order, 0 .. 2^N_IN-1.
//  - vec_out wraps: at the last vector no increment occurs; vec_out returns to 0 with DONE.
//  - Completion: on the sampling edge of the last vector, busy=0, done=1, and
//    equal=(final err_count==0).
//  - Latency from E0 to done high = 2^N_IN*(SETTLE+1) cycles. done drops next cycle.
//  - Results hold until the next accepted start.
//  - start while busy, or in the done cycle, is ignored. start held high in IDLE restarts
//    a sweep each time.
//  - err_count saturates naturally: its width holds 2^N_IN exactly.
//  - rst_n low mid-sweep: immediate return to IDLE, all outputs 0, no done pulse.
//  - Inputs must be 0/1; X/Z on f_ref/f_dut is outside the contract.
// CONFIGURATION
//  - CHK_STOP_FIRST_EN defined: the sweep terminates on the sampling edge of the first
//    mismatch. done=1, busy=0, err_count=1, and tt bits of unvisited vectors stay 0.
//    A fully equal sweep behaves as without the macro.
//  - CHK_STOP_FIRST_EN undefined: always sweeps all 2^N_IN vectors.
// TESTING (N_IN=2, SETTLE=1 unless noted)
//  1. f_ref=f_dut=x&~y, start pulse -> done after 8 cycles. tt_ref=tt_dut=4'b0100,
//     equal=1, err_count=0, first_mm_vld=0.
//  2. f_ref=x&~y, f_dut=x|~y -> tt_dut=4'b1101, err_count=2, first_mm_vec=2'b00,
//     equal=0. With CHK_STOP_FIRST_EN: done after 2 cycles, err_count=1.
//  3. SETTLE=0, f_ref=f_dut=x|y -> done exactly 4 cycles after start, tt=4'b1110.
//     vec_out steps 0,1,2,3 one per cycle.
//  4. start re-pulsed during sweep at cycle 3 -> ignored. Single done at cycle 8 and
//     results unchanged vs scenario 1.
//  5. rst_n low at cycle 5 of sweep -> all outputs 0 asynchronously, no done. A new start
//     after release gives a full correct sweep.
//  6. N_IN=3, f_ref=~(~x&~y)&(x|y), f_dut=x|y -> tt=8'b11111100, equal=1,
//     done at 16 cycles.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// ---------------------------------------------------------------------------
// truth_table_checker_if
// Bundles the sweep control, the function-pair sample inputs and the result
// outputs of truth_table_checker into one port.
//   start         : request a new sweep (driven by master)
//   f_ref, f_dut  : original / simplified function outputs for vec_out (master)
//   vec_out       : vector currently applied to both functions (slave)
//   busy, done    : sweep in progress / one-cycle completion pulse (slave)
//   equal         : last sweep found no mismatch (slave)
//   err_count     : number of mismatching vectors (slave)
//   first_mm_vld  : first_mm_vec holds a valid vector (slave)
//   first_mm_vec  : lowest vector with f_ref != f_dut (slave)
//   tt_ref/tt_dut : recorded truth tables, bit v = sample at vector v (slave)
// Modports: master = stimulus/status side, slave = the checker itself.
// ---------------------------------------------------------------------------
interface truth_table_checker_if #(
    parameter int N_IN = 3
);
    logic                    start;
    logic                    f_ref;
    logic                    f_dut;
    logic [N_IN-1:0]         vec_out;
    logic                    busy;
    logic                    done;
    logic                    equal;
    logic [N_IN:0]           err_count;
    logic                    first_mm_vld;
    logic [N_IN-1:0]         first_mm_vec;
    logic [(1<<N_IN)-1:0]    tt_ref;
    logic [(1<<N_IN)-1:0]    tt_dut;

    modport master (
        output start, f_ref, f_dut,
        input  vec_out, busy, done, equal, err_count,
               first_mm_vld, first_mm_vec, tt_ref, tt_dut
    );

    modport slave (
        input  start, f_ref, f_dut,
        output vec_out, busy, done, equal, err_count,
               first_mm_vld, first_mm_vec, tt_ref, tt_dut
    );
endinterface

// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
// Sequential exhaustive-sweep equivalence checker for an N_IN-input Boolean
// function pair. Walks vec_out through every vector in ascending order,
// samples f_ref and f_dut at the end of each hold window, records both truth
// tables and reports mismatch count, first mismatching vector and equality.
// Parameters:
//   N_IN   : number of function inputs (vec_out MSB is x, then y, z ...)
//   SETTLE : extra hold cycles per vector before sampling (0 allowed)
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : truth_table_checker_if.slave (start, f_ref, f_dut in; results out)
// Optional feature macro: CHK_STOP_FIRST_EN -- when defined the sweep ends on
// the sampling edge of the first mismatching vector.
// ---------------------------------------------------------------------------
module truth_table_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  bus
);

    localparam int NUM_VEC = 1 << N_IN;
    // The hold counter needs at least one bit even when SETTLE is 0.
    localparam int HOLD_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 equal_q, equal_d;
    logic [N_IN:0]        err_count_q, err_count_d;
    logic                 first_mm_vld_q, first_mm_vld_d;
    logic [N_IN-1:0]      first_mm_vec_q, first_mm_vec_d;
    logic [NUM_VEC-1:0]   tt_ref_q, tt_ref_d;
    logic [NUM_VEC-1:0]   tt_dut_q, tt_dut_d;
    logic                 mismatch;
    logic                 stop;

    assign mismatch = bus.f_ref ^ bus.f_dut;

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        vec_d          = vec_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        equal_d        = equal_q;
        err_count_d    = err_count_q;
        first_mm_vld_d = first_mm_vld_q;
        first_mm_vec_d = first_mm_vec_q;
        tt_ref_d       = tt_ref_q;
        tt_dut_d       = tt_dut_q;
        stop           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d        = ST_HOLD;
                    busy_d         = 1'b1;
                    hold_d         = '0;
                    vec_d          = '0;
                    equal_d        = 1'b0;
                    err_count_d    = '0;
                    first_mm_vld_d = 1'b0;
                    first_mm_vec_d = '0;
                    tt_ref_d       = '0;
                    tt_dut_d       = '0;
                end
            end

            ST_HOLD: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    // Sampling edge: this ends the hold window of vec_q.
                    hold_d           = '0;
                    tt_ref_d[vec_q]  = bus.f_ref;
                    tt_dut_d[vec_q]  = bus.f_dut;
                    if (mismatch) begin
                        err_count_d = err_count_q + (N_IN+1)'(1);
                        if (!first_mm_vld_q) begin
                            first_mm_vld_d = 1'b1;
                            first_mm_vec_d = vec_q;
                        end
                    end
                    stop = (vec_q == VEC_LAST);
`ifdef CHK_STOP_FIRST_EN
                    if (mismatch) begin
                        stop = 1'b1;
                    end
`else
`endif
                    if (stop) begin
                        // vec_out returns to 0 together with the done pulse.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
                        equal_d = (err_count_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end

            ST_DONE: begin
                // start is deliberately ignored in the done cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            vec_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            equal_q        <= 1'b0;
            err_count_q    <= '0;
            first_mm_vld_q <= 1'b0;
            first_mm_vec_q <= '0;
            tt_ref_q       <= '0;
            tt_dut_q       <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            vec_q          <= vec_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            equal_q        <= equal_d;
            err_count_q    <= err_count_d;
            first_mm_vld_q <= first_mm_vld_d;
            first_mm_vec_q <= first_mm_vec_d;
            tt_ref_q       <= tt_ref_d;
            tt_dut_q       <= tt_dut_d;
        end
    end

    assign bus.vec_out      = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.equal        = equal_q;
    assign bus.err_count    = err_count_q;
    assign bus.first_mm_vld = first_mm_vld_q;
    assign bus.first_mm_vec = first_mm_vec_q;
    assign bus.tt_ref       = tt_ref_q;
    assign bus.tt_dut       = tt_dut_q;

endmodule
